// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared definitions for the BIST loop: controller state
//                encoding, default pattern/signature width and the default
//                LFSR seed and feedback mask (also used by the MISR and its
//                benches).
//  Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

    // Default pattern / signature width, shared with the downstream MISR.
    localparam int c_DEFAULT_WIDTH = 4;

    // Default LFSR load value and feedback mask (x^4 + x^3 + 1, period 15).
    localparam logic [c_DEFAULT_WIDTH-1:0] c_DEFAULT_SEED = 4'b0001;
    localparam logic [c_DEFAULT_WIDTH-1:0] c_DEFAULT_TAPS = 4'b1100;

    // Controller state encoding.
    localparam int         c_STATE_W    = 3;
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CLEAR   = 3'd1;
    localparam logic [2:0] c_ST_RUN     = 3'd2;
    localparam logic [2:0] c_ST_FLUSH   = 3'd3;
    localparam logic [2:0] c_ST_COMPARE = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE    = c_ST_IDLE,
        CLEAR   = c_ST_CLEAR,
        RUN     = c_ST_RUN,
        FLUSH   = c_ST_FLUSH,
        COMPARE = c_ST_COMPARE,
        DONE    = c_ST_DONE
    } bist_state_t;

    // An all-zero LFSR state locks up, so a zero seed is replaced by 1.
    function automatic logic [31:0] safeSeed(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage : bist_pkg
`default_nettype wire

// File: rtl/lfsr_tpg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_tpg
//  Description : Fibonacci LFSR test-pattern generator, shifting left.
//                next = {state[WIDTH-2:0], ^(state & TAPS)}.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous, active-low; loads SEED
//                load   - reload SEED (priority over enable)
//                enable - advance one step
//                state  - current pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_tpg
    import bist_pkg::*;
#(
    parameter int               WIDTH = c_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(c_DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_DEFAULT_TAPS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] c_SEED = WIDTH'(safeSeed(32'(SEED)));

    logic [WIDTH-1:0] r_state;
    logic             w_feedback;

    assign w_feedback = ^(r_state & TAPS);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_SEED;
        end else if (load) begin
            r_state <= c_SEED;
        end else if (enable) begin
            r_state <= {r_state[WIDTH-2:0], w_feedback};
        end
    end

    assign state = r_state;

endmodule : lfsr_tpg
`default_nettype wire

// File: rtl/bist_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bist_controller
//  Description : BIST sequencer. Clears the MISR, drives NUM_PATTERNS LFSR
//                patterns into the CUT, optionally flushes the CUT pipeline,
//                then captures the MISR signature and compares it with
//                GOLDEN_SIG.
//  Ports       : clock       - rising-edge clock
//                reset       - synchronous, active-low
//                start       - level; starts a run from IDLE or DONE
//                misr_sig    - current MISR signature
//                tpg_pattern - test pattern to the CUT
//                test_mode   - selects tpg_pattern into the CUT
//                misr_rst    - active-high MISR clear
//                busy        - high from CLEAR through COMPARE
//                done        - run complete, results valid
//                pass        - signature matched GOLDEN_SIG (valid with done)
//                signature   - signature captured in COMPARE
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_controller
    import bist_pkg::*;
#(
    parameter int               WIDTH        = c_DEFAULT_WIDTH,
    parameter int               NUM_PATTERNS = 15,
    parameter int               CNT_W        = 8,
    parameter int               PIPE_DEPTH   = 0,
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(c_DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(c_DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] misr_sig,
    output logic [WIDTH-1:0] tpg_pattern,
    output logic             test_mode,
    output logic             misr_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    // Terminal counts: RUN ends on its last pattern, FLUSH after PIPE_DEPTH
    // cycles. The counter is shared by both phases and zeroed on each exit.
    localparam logic [CNT_W-1:0] c_RUN_LAST   = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] c_FLUSH_LAST = CNT_W'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);
    localparam bit               c_HAS_FLUSH  = (PIPE_DEPTH > 0);

    bist_state_t      r_state;
    bist_state_t      w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_pass;
    logic [WIDTH-1:0] r_signature;

    logic             w_testMode;
    logic             w_misrRst;
    logic             w_busy;
    logic             w_lfsrLoad;
    logic             w_lfsrEnable;
    logic [WIDTH-1:0] w_lfsrState;

    // ------------------------------------------------------------------
    // Pattern generator
    // ------------------------------------------------------------------
    lfsr_tpg #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsrTpg (
        .clock  (clock),
        .reset  (reset),
        .load   (w_lfsrLoad),
        .enable (w_lfsrEnable),
        .state  (w_lfsrState)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = CLEAR;
                end
            end
            CLEAR: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (r_cnt == c_RUN_LAST) begin
                    if (c_HAS_FLUSH) begin
                        w_nextState = FLUSH;
                    end else begin
                        w_nextState = COMPARE;
                    end
                end
            end
            FLUSH: begin
                if (r_cnt == c_FLUSH_LAST) begin
                    w_nextState = COMPARE;
                end
            end
            COMPARE: begin
                w_nextState = DONE;
            end
            DONE: begin
                // Holding start high here gives back-to-back runs with a
                // single DONE cycle between them.
                if (start) begin
                    w_nextState = CLEAR;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the current state only
    // ------------------------------------------------------------------
    always_comb begin
        w_testMode   = 1'b0;
        w_misrRst    = 1'b0;
        w_busy       = 1'b0;
        w_lfsrLoad   = 1'b0;
        w_lfsrEnable = 1'b0;
        case (r_state)
            IDLE: begin
                w_misrRst = 1'b1;
            end
            CLEAR: begin
                w_misrRst  = 1'b1;
                w_testMode = 1'b1;
                w_busy     = 1'b1;
                w_lfsrLoad = 1'b1;
            end
            RUN: begin
                w_testMode   = 1'b1;
                w_busy       = 1'b1;
                w_lfsrEnable = 1'b1;
            end
            FLUSH, COMPARE: begin
                // MISR keeps capturing while the CUT pipeline drains; the
                // LFSR holds.
                w_testMode = 1'b1;
                w_busy     = 1'b1;
            end
            DONE: begin
                // MISR neither cleared nor fed, so it keeps its signature.
            end
            default: begin
                w_misrRst = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern/flush counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_signature <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= '0;
                end
                RUN, FLUSH: begin
                    if (w_nextState != r_state) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                COMPARE: begin
                    r_signature <= misr_sig;
                    r_pass      <= (misr_sig == GOLDEN_SIG);
                    r_done      <= 1'b1;
                end
                default: begin
                end
            endcase
            // A new run invalidates the previous verdict as soon as it is
            // accepted, so done never overlaps busy. The signature is kept
            // until the next COMPARE overwrites it.
            if (w_nextState == CLEAR) begin
                r_done <= 1'b0;
                r_pass <= 1'b0;
            end
        end
    end

    assign tpg_pattern = w_lfsrState;
    assign test_mode   = w_testMode;
    assign misr_rst    = w_misrRst;
    assign busy        = w_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign signature   = r_signature;

endmodule : bist_controller
`default_nettype wire

// File: tb/tb_bist_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_controller
//  Description : Self-checking bench for bist_controller. Three controllers
//                (default, PIPE_DEPTH=2, NUM_PATTERNS=16) each close a loop
//                through a small CUT model and a 4-bit MISR model. Expected
//                patterns come from the published LFSR sequence table and
//                expected signatures from folding CUT responses through the
//                MISR rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_controller;
    import bist_pkg::*;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [3:0] patTab(input int i);
        case (i % 15)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0100;
            3:       return 4'b1001;
            4:       return 4'b0011;
            5:       return 4'b0110;
            6:       return 4'b1101;
            7:       return 4'b1010;
            8:       return 4'b0101;
            9:       return 4'b1011;
            10:      return 4'b0111;
            11:      return 4'b1111;
            12:      return 4'b1110;
            13:      return 4'b1100;
            default: return 4'b1000;
        endcase
    endfunction

    // Arbitrary combinational CUT.
    function automatic logic [3:0] cutF(input logic [3:0] p);
        logic [3:0] prod;
        prod = p * 4'd5;
        return (prod + 4'd3) ^ {p[0], p[3:1]};
    endfunction

    // 4-bit MISR: shift left with feedback, XOR in the response.
    function automatic logic [3:0] misrStep(input logic [3:0] m, input logic [3:0] r);
        return {m[2:0], ^(m & c_DEFAULT_TAPS)} ^ r;
    endfunction

    // Signature after n patterns, with an optional single-bit fault at
    // pattern index fc (fc < 0 means no fault).
    function automatic logic [3:0] refSig(input int n, input int fc, input int fb);
        logic [3:0] m;
        logic [3:0] r;
        m = 4'd0;
        for (int i = 0; i < n; i++) begin
            r = cutF(patTab(i));
            if (i == fc) r = r ^ 4'(1 << fb);
            m = misrStep(m, r);
        end
        return m;
    endfunction

    localparam logic [3:0] c_GOLD15 = refSig(15, -1, 0);
    localparam logic [3:0] c_GOLD16 = refSig(16, -1, 0);

    // ------------------------------------------------------------------
    // Clock, stimulus, DUTs
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic       startV [3];
    logic [3:0] injV   [3];

    logic [3:0] tpgA, tpgF, tpgW, sigA, sigF, sigW, misrA, misrF, misrW, pipe1, pipe2;
    logic       tmA, tmF, tmW, mrA, mrF, mrW, busyA, busyF, busyW;
    logic       doneA, doneF, doneW, passA, passF, passW;

    bist_controller #(.GOLDEN_SIG(c_GOLD15)) u_dutA (
        .clock(clk), .reset(rstN), .start(startV[0]), .misr_sig(misrA),
        .tpg_pattern(tpgA), .test_mode(tmA), .misr_rst(mrA), .busy(busyA),
        .done(doneA), .pass(passA), .signature(sigA));

    bist_controller #(.PIPE_DEPTH(2), .GOLDEN_SIG(c_GOLD15)) u_dutF (
        .clock(clk), .reset(rstN), .start(startV[1]), .misr_sig(misrF),
        .tpg_pattern(tpgF), .test_mode(tmF), .misr_rst(mrF), .busy(busyF),
        .done(doneF), .pass(passF), .signature(sigF));

    bist_controller #(.NUM_PATTERNS(16), .GOLDEN_SIG(c_GOLD16)) u_dutW (
        .clock(clk), .reset(rstN), .start(startV[2]), .misr_sig(misrW),
        .tpg_pattern(tpgW), .test_mode(tmW), .misr_rst(mrW), .busy(busyW),
        .done(doneW), .pass(passW), .signature(sigW));

    // MISR / CUT models; the F loop has a 2-stage CUT cleared with the MISR.
    always @(posedge clk) begin
        if (mrA) misrA <= 4'd0;
        else if (tmA) misrA <= misrStep(misrA, cutF(tpgA) ^ injV[0]);
        if (mrW) misrW <= 4'd0;
        else if (tmW) misrW <= misrStep(misrW, cutF(tpgW) ^ injV[2]);
        if (mrF) begin
            misrF <= 4'd0; pipe1 <= 4'd0; pipe2 <= 4'd0;
        end else if (tmF) begin
            pipe1 <= cutF(tpgF) ^ injV[1];
            pipe2 <= pipe1;
            misrF <= misrStep(misrF, pipe2);
        end
    end

    // Indexed views of the three DUTs for the run task.
    logic [3:0] tpgV [3];
    logic [3:0] sigV [3];
    logic       tmV [3], mrV [3], busyV [3], doneV [3], passV [3];
    always_comb begin
        tpgV[0] = tpgA; tpgV[1] = tpgF; tpgV[2] = tpgW;
        sigV[0] = sigA; sigV[1] = sigF; sigV[2] = sigW;
        tmV[0] = tmA; tmV[1] = tmF; tmV[2] = tmW;
        mrV[0] = mrA; mrV[1] = mrF; mrV[2] = mrW;
        busyV[0] = busyA; busyV[1] = busyF; busyV[2] = busyW;
        doneV[0] = doneA; doneV[1] = doneF; doneV[2] = doneW;
        passV[0] = passA; passV[1] = passF; passV[2] = passW;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One run on DUT d. Called and returns at a negedge. fCyc/midAt/rstAt
    // are RUN-cycle indices, negative to disable. hold keeps start high.
    task automatic doRun(input int d, input int nPat, input int pipe, input int fCyc,
                         input int fBit, input int midAt, input int rstAt, input bit hold);
        logic [3:0] expSig;
        logic [3:0] gold;
        expSig = refSig(nPat, fCyc, fBit);
        gold   = (d == 2) ? c_GOLD16 : c_GOLD15;
        if (!startV[d]) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            startV[d] = 1'b1;
        end
        @(posedge clk);                      // E0 samples start
        if (!hold) #1 startV[d] = 1'b0;
        @(negedge clk);                      // CLEAR
        checkVal("clear_ctrl", {busyV[d], mrV[d], tmV[d]}, 3'b111);
        for (int k = 0; k < nPat; k++) begin
            @(negedge clk);                  // RUN cycle k
            checkVal("run_pattern", tpgV[d], patTab(k));
            checkVal("run_ctrl", {busyV[d], mrV[d], tmV[d], doneV[d]}, 4'b1010);
            if (k == rstAt) begin
                rstN = 1'b0; injV[d] = 4'd0; startV[d] = 1'b0;
                @(negedge clk);
                checkVal("midrun_reset_outputs",
                         {tpgV[d], tmV[d], mrV[d], busyV[d], doneV[d], passV[d], sigV[d]},
                         {4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
                rstN = 1'b1;
                return;
            end
            injV[d] = (k == fCyc) ? 4'(1 << fBit) : 4'd0;
            if (!hold) startV[d] = (k == midAt);
        end
        @(negedge clk);                      // first cycle after RUN
        injV[d] = 4'd0;
        if (!hold) startV[d] = 1'b0;
        for (int j = 0; j < pipe; j++) begin
            checkVal("flush_lfsr_hold", tpgV[d], patTab(nPat));
            checkVal("flush_busy", {busyV[d], tmV[d], doneV[d]}, 3'b110);
            @(negedge clk);
        end
        checkVal("compare_ctrl", {busyV[d], mrV[d], tmV[d], doneV[d]}, 4'b1010);
        @(negedge clk);                      // DONE: E0 + nPat + pipe + 2
        checkVal("done_ctrl", {busyV[d], mrV[d], tmV[d], doneV[d]}, 4'b0001);
        checkVal("signature", sigV[d], expSig);
        checkVal("pass", passV[d], (expSig == gold));
        if (fCyc >= 0) checkVal("fault_sig_differs", (sigV[d] != gold), 1);
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        int fc;
        rstN = 1'b0;
        for (int d = 0; d < 3; d++) begin
            startV[d] = 1'b0;
            injV[d]   = 4'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkVal("reset_outputs",
                     {tpgV[d], tmV[d], mrV[d], busyV[d], doneV[d], passV[d], sigV[d]},
                     {4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
        end
        rstN = 1'b1;

        doRun(0, 15, 0, -1, 0, -1, -1, 1'b0);                         // golden
        doRun(0, 15, 0, 5, int'($urandom_range(0, 3)), -1, -1, 1'b0);  // fault, cycle 5
        for (int i = 0; i < 4; i++) begin
            fc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 14)) : -1;
            doRun(0, 15, 0, fc, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 14)), -1, 1'b0);
        end
        doRun(0, 15, 0, -1, 0, -1, 7, 1'b0);                          // reset at RUN 7
        doRun(0, 15, 0, -1, 0, -1, -1, 1'b0);                         // clean rerun
        doRun(0, 15, 0, -1, 0, -1, -1, 1'b1);                         // start held
        doRun(0, 15, 0, -1, 0, -1, -1, 1'b0);                         // back-to-back
        doRun(1, 15, 2, -1, 0, -1, -1, 1'b0);                         // flush
        doRun(2, 16, 0, -1, 0, -1, -1, 1'b0);                         // wrap

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d)", nChecks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bist_controller
`default_nettype wire
